tx_fifo_ctrl: RTL and testbench
===============================

TX_FIFO_CTRL -- requirements
Module: tx_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of stored words, power of two, minimum 2.
REQ-002 Parameter WIDTH, default 12, word width, equal to the width of the transmit register.
REQ-003 Parameter CNTW, default 4, count width, equal to log2(DEPTH)+1.
REQ-004 PCLK_tx  input  1  clock; all state updates on its rising edge.
REQ-005 PRESETn_tx  input  1  reset, asynchronous, active-low.
REQ-006 wr_en_i  input  1  write-enable level from the APB register block; may stay high for many cycles.
REQ-007 wr_data_i  input  WIDTH  transmit word; valid in the cycle wr_en_i first reads high.
REQ-008 rd_ready_i  input  1  downstream frame engine accepts the head word.
REQ-009 clr_flags_i  input  1  clears the sticky error flags.
REQ-010 rd_valid_o  output  1  head word available.
REQ-011 rd_data_o  output  WIDTH  head word, first-word-fall-through.
REQ-012 status_o  output  8  status byte returned to the APB register block.

Function
REQ-013 Push shall occur on the rising edge of wr_en_i only: push = wr_en_i AND NOT wr_en_d, where wr_en_d is wr_en_i registered once.
REQ-014 A level held high on wr_en_i for N cycles shall produce exactly one push.
REQ-015 Pop shall occur when rd_valid_o AND rd_ready_i are both high in the same cycle.
REQ-016 Storage shall be a DEPTH-entry array with write pointer, read pointer and count, each of CNTW bits.
REQ-017 Pointers shall wrap to 0 after entry DEPTH-1.
REQ-018 rd_valid_o shall equal (count != 0).
REQ-019 rd_data_o shall be the entry at the read pointer, combinational from the array.
REQ-020 rd_data_o is don't-care while rd_valid_o is low.
REQ-021 A word pushed at edge k shall appear on rd_valid_o/rd_data_o after edge k when the FIFO was empty: one-cycle latency, no bypass.
REQ-022 When not full, a push shall write wr_data_i at the write pointer, advance the write pointer and increment count.
REQ-023 A pop shall advance the read pointer and decrement count.
REQ-024 Push and pop in the same cycle, count between 1 and DEPTH-1, shall perform both; count is unchanged.
REQ-025 Push and pop in the same cycle with the FIFO full shall accept the push: the pop frees the slot, count stays at DEPTH, overflow is not set.
REQ-026 Push with the FIFO full and no pop shall drop the word, leave pointers and count unchanged, and set ovf.
REQ-027 rd_ready_i high while the FIFO is empty shall cause no pop and shall set udf.
REQ-028 ovf and udf shall be sticky and cleared only by clr_flags_i or reset.
REQ-029 clr_flags_i has priority over a set event in the same cycle.
REQ-030 status_o[7] = full (count == DEPTH); this bit gates APB writes to the transmit register.
REQ-031 status_o[6] = empty.
REQ-032 status_o[5] = ovf.
REQ-033 status_o[4] = udf.
REQ-034 status_o[3:0] = count, saturating at 15 for DEPTH > 15.
REQ-035 All status_o bits shall be registered or derived combinationally from registered state; there shall be no path from inputs to status_o.

Reset
REQ-036 Asserting PRESETn_tx low, including mid-operation, shall immediately clear the pointers, count, ovf, udf and wr_en_d.
REQ-037 During reset, status_o = 8'h40, rd_valid_o = 0, and any queued data is discarded.
REQ-038 Array contents need no reset.
REQ-039 If wr_en_i is high when reset releases, it shall count as a rising edge and push on the first clock.

Verification
REQ-040 After reset, push 12'hA5C via wr_en_i held high for 5 cycles -> exactly one push; next cycle rd_valid_o=1, rd_data_o=12'hA5C, status_o=8'h01.
REQ-041 Push 8 words 1..8, then a 9th push (12'h0FF) -> status_o=8'hA8; draining yields 1..8 in order, 12'h0FF never appears, final status_o=8'h60 (empty, ovf sticky).
REQ-042 FIFO full, then push 12'h123 with rd_ready_i=1 in the same cycle -> status_o stays 8'h88, ovf=0, and 12'h123 is the last word read.
REQ-043 Empty FIFO, rd_ready_i=1 for one cycle -> status_o=8'h50; assert clr_flags_i -> status_o=8'h40.
REQ-044 Push 20 words with continuous interleaved pops -> pointer wrap-around, FIFO order preserved, count never exceeds 8.
REQ-045 With 3 words queued, pulse PRESETn_tx low asynchronously between clock edges -> rd_valid_o=0 and status_o=8'h40 at once, with no clock edge required.

Source files
------------

// File: rtl/tx_fifo_ctrl.sv
// Transmit FIFO controller: edge-triggered push from an APB write-enable level,
// first-word-fall-through read side, sticky overflow/underflow flags and a status byte.
module tx_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12,
    parameter int CNTW  = 4
) (
    input  logic             PCLK_tx,
    input  logic             PRESETn_tx,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    input  logic             clr_flags_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [7:0]       status_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNTW-1:0]  r_wr_ptr;
    logic [CNTW-1:0]  r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             r_wr_en_d;
    logic             r_ovf;
    logic             r_udf;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_ovf_set;
    logic w_udf_set;

    function automatic logic [CNTW-1:0] ptr_inc(input logic [CNTW-1:0] p);
        return (p == CNTW'(DEPTH - 1)) ? '0 : p + CNTW'(1);
    endfunction

    // Status nibble only has four bits; deeper FIFOs report 15 once past it.
    function automatic logic [3:0] sat_count(input logic [CNTW-1:0] c);
        return (32'(c) > 32'd15) ? 4'hF : 4'(c);
    endfunction

    assign w_full    = (r_count == CNTW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = wr_en_i & ~r_wr_en_d;
    assign w_pop     = ~w_empty & rd_ready_i;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign w_wr_acc  = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_udf_set = rd_ready_i & w_empty;

    always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
        if (!PRESETn_tx) begin
            r_wr_en_d <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_wr_en_d <= wr_en_i;
            if (w_wr_acc)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (clr_flags_i) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_ovf_set)
                    r_ovf <= 1'b1;
                if (w_udf_set)
                    r_udf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are never visible while count is zero.
    always_ff @(posedge PCLK_tx) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
    end

    assign rd_valid_o = ~w_empty;
    assign rd_data_o  = r_mem[r_rd_ptr[AW-1:0]];
    assign status_o   = {w_full, w_empty, r_ovf, r_udf, sat_count(r_count)};

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Bench for tx_fifo_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_tx_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 12;
    localparam int CNTW  = 4;

    logic             PCLK_tx;
    logic             PRESETn_tx;
    logic             wr_en_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_ready_i;
    logic             clr_flags_i;
    logic             rd_valid_o;
    logic [WIDTH-1:0] rd_data_o;
    logic [7:0]       status_o;

    int n_checks;
    int n_errs;

    logic [WIDTH-1:0] m_q[$];
    logic             m_wr_prev;
    logic             m_ovf;
    logic             m_udf;

    tx_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .PCLK_tx    (PCLK_tx),
        .PRESETn_tx (PRESETn_tx),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .rd_ready_i (rd_ready_i),
        .clr_flags_i(clr_flags_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .status_o   (status_o)
    );

    initial PCLK_tx = 1'b0;
    always #5 PCLK_tx = ~PCLK_tx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int sz = m_q.size();
        return {sz == DEPTH, sz == 0, m_ovf, m_udf, 4'((sz > 15) ? 15 : sz)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_wr_prev = 1'b0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
    endtask

    // One clock of the FIFO's rules, evaluated on the inputs present before the edge.
    task automatic model_step();
        int  sz = m_q.size();
        bit  push = wr_en_i && !m_wr_prev;
        bit  pop  = (sz != 0) && rd_ready_i;
        bit  udfs = rd_ready_i && (sz == 0);
        bit  ovfs = push && (sz == DEPTH) && !pop;
        if (pop)
            void'(m_q.pop_front());
        if (push && (sz < DEPTH || pop))
            m_q.push_back(wr_data_i);
        if (clr_flags_i) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (ovfs) m_ovf = 1'b1;
            if (udfs) m_udf = 1'b1;
        end
        m_wr_prev = wr_en_i;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(rd_valid_o), 32'(m_q.size() != 0));
        chk({tag, "_status"}, 32'(status_o), 32'(exp_status()));
        if (m_q.size() != 0)
            chk({tag, "_data"}, 32'(rd_data_o), 32'(m_q[0]));
    endtask

    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic cyc(input string tag);
        model_step();
        @(posedge PCLK_tx);
        #1;
        check_all(tag);
    endtask

    // Asserts reset between edges, checks the reset state, releases after the next edge.
    task automatic do_reset();
        #2;
        PRESETn_tx = 1'b0;
        #1;
        model_reset();
        chk("rst_status", 32'(status_o), 32'h40);
        chk("rst_valid", 32'(rd_valid_o), 32'h0);
        @(posedge PCLK_tx);
        #1;
        PRESETn_tx = 1'b1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d, input string tag);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        cyc(tag);
        wr_en_i   = 1'b0;
        wr_data_i = $urandom;
        cyc(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_errs      = 0;
        PRESETn_tx  = 1'b0;
        wr_en_i     = 1'b0;
        wr_data_i   = '0;
        rd_ready_i  = 1'b0;
        clr_flags_i = 1'b0;
        model_reset();
        @(posedge PCLK_tx);
        #1;
        do_reset();

        // Level held for five cycles yields one push; data changes while held are ignored.
        wr_en_i   = 1'b1;
        wr_data_i = 12'hA5C;
        cyc("hold");
        chk("hold_data", 32'(rd_data_o), 32'hA5C);
        chk("hold_stat", 32'(status_o), 32'h01);
        for (int i = 0; i < 4; i++) begin
            wr_data_i = 12'h100 + 12'(i);
            cyc("hold");
        end
        chk("hold_once", 32'(status_o), 32'h01);
        wr_en_i = 1'b0;
        cyc("hold");

        // Overflow: nine pushes into eight slots, then drain in order.
        do_reset();
        for (int i = 1; i <= 8; i++)
            push_word(12'(i), "fill");
        push_word(12'h0FF, "ovf");
        chk("ovf_stat", 32'(status_o), 32'hA8);
        rd_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(rd_data_o), 32'(i));
            cyc("drain");
        end
        rd_ready_i = 1'b0;
        chk("drain_final", 32'(status_o), 32'h60);

        // Full FIFO with simultaneous push and pop keeps the new word.
        do_reset();
        for (int i = 1; i <= 8; i++)
            push_word(12'(i + 16), "fill2");
        chk("full_stat", 32'(status_o), 32'h88);
        wr_en_i    = 1'b1;
        wr_data_i  = 12'h123;
        rd_ready_i = 1'b1;
        cyc("fullpp");
        chk("fullpp_stat", 32'(status_o), 32'h88);
        wr_en_i = 1'b0;
        for (int i = 0; i < 7; i++)
            cyc("fullpp_drain");
        chk("fullpp_last", 32'(rd_data_o), 32'h123);
        cyc("fullpp_drain");
        rd_ready_i = 1'b0;
        chk("fullpp_empty", 32'(status_o), 32'h40);

        // Underflow and flag clear.
        do_reset();
        rd_ready_i = 1'b1;
        cyc("udf");
        rd_ready_i = 1'b0;
        chk("udf_stat", 32'(status_o), 32'h50);
        clr_flags_i = 1'b1;
        cyc("clr");
        clr_flags_i = 1'b0;
        chk("clr_stat", 32'(status_o), 32'h40);

        // Clear wins over a same-cycle underflow.
        rd_ready_i  = 1'b1;
        clr_flags_i = 1'b1;
        cyc("clr_prio");
        chk("clr_prio_stat", 32'(status_o), 32'h40);
        rd_ready_i  = 1'b0;
        clr_flags_i = 1'b0;

        // Write enable already high at reset release pushes on the first edge.
        wr_en_i   = 1'b1;
        wr_data_i = 12'h3C3;
        do_reset();
        wr_data_i = 12'h3C3;
        cyc("rel");
        chk("rel_valid", 32'(rd_valid_o), 32'h1);
        chk("rel_data", 32'(rd_data_o), 32'h3C3);
        wr_en_i = 1'b0;
        cyc("rel");

        // Twenty pushes with interleaved pops wrap the pointers.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr_en_i    = 1'b1;
            wr_data_i  = 12'($urandom);
            rd_ready_i = (i > 2) ? 1'($urandom) : 1'b0;
            cyc("wrap");
            wr_en_i    = 1'b0;
            rd_ready_i = 1'($urandom);
            cyc("wrap");
            chk("wrap_le8", 32'(status_o[3:0] <= 4'd8), 32'h1);
        end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc("wrap_drain");
        rd_ready_i = 1'b0;

        // Randomized traffic, write enable biased to toggle, occasional clears.
        for (int i = 0; i < 600; i++) begin
            wr_en_i     = ($urandom_range(0, 99) < 55);
            wr_data_i   = 12'($urandom);
            rd_ready_i  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            clr_flags_i = ($urandom_range(0, 99) < 4);
            cyc("rand");
        end
        wr_en_i     = 1'b0;
        rd_ready_i  = 1'b0;
        clr_flags_i = 1'b0;
        cyc("rand_end");

        // Asynchronous reset with three words queued, checked before any edge.
        do_reset();
        for (int i = 0; i < 3; i++)
            push_word(12'h200 + 12'(i), "async");
        chk("async_pre", 32'(status_o), 32'h03);
        #2;
        PRESETn_tx = 1'b0;
        #1;
        model_reset();
        chk("async_valid", 32'(rd_valid_o), 32'h0);
        chk("async_stat", 32'(status_o), 32'h40);
        @(posedge PCLK_tx);
        #1;
        PRESETn_tx = 1'b1;
        cyc("async_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
